ex_operand_stage: RTL
=====================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports stall, flush  input  1 each  hold / squash request from hazard control.
REQ-004 SHALL have ports idValid, idUsesA, idUsesB, idUseImm, idIsLoad, idRegWrite  input  1 each  decode-stage qualifiers.
REQ-005 SHALL have ports idRegA, idRegB, idImm  input  16 each  register-file reads and extended immediate.
REQ-006 SHALL have ports idSrcA, idSrcB, idDest  input  3 each  source and destination register numbers.
REQ-007 SHALL have ports idAluOp  input  3, and idInvA, idInvB, idCin, idSign  input  1 each  ALU controls.
REQ-008 SHALL have ports exmRegWrite, mwbRegWrite  input  1, exmDest, mwbDest  input  3, exmData, mwbData  input  16  writeback-forwarding sources.
REQ-009 SHALL have ports exValid, exRegWrite, exIsLoad  output  1  registered qualifiers.
REQ-010 SHALL have ports exA, exB  output  16  registered ALU operands A and B.
REQ-011 SHALL have ports exOp  output  3, exInvA, exInvB, exCin, exSign  output  1, exDest  output  3  registered ALU controls and destination.
REQ-012 SHALL have port hazardStall  output  1  combinational stall request to upstream.

Function
REQ-013 SHALL update registers only on rising clk; priority per edge: rst > flush > stall > capture.
REQ-014 On flush (no rst), SHALL clear exValid, exRegWrite and exIsLoad to 0; other fields hold their values.
REQ-015 On stall (no rst or flush), SHALL hold all outputs unchanged, including exA and exB.
REQ-016 On capture, SHALL load all ex* fields from the id* fields; exValid = idValid; exRegWrite = idRegWrite & idValid.
REQ-017 Operand A capture SHALL select exmData when exmRegWrite and exmDest==idSrcA, else mwbData when mwbRegWrite and mwbDest==idSrcA, else idRegA.
REQ-018 Operand B capture SHALL be idImm when idUseImm, else the REQ-017 rule applied to idSrcB/idRegB.
REQ-019 All eight register numbers, including 0, SHALL be forwardable.
REQ-020 With both forwarding sources matching, the EX/MEM source SHALL win.
REQ-021 A capture with idValid=0 SHALL drive hazardStall=0 for that cycle.
REQ-022 A combined stall and hazardStall condition SHALL be treated as stall by this block; freezing the ID stage is upstream's responsibility.
REQ-023 Latency SHALL be one cycle from ID inputs to ex* outputs.

Reset
REQ-024 On rst, SHALL set every output register to 0, including exValid and all data and control fields.
REQ-025 rst asserted mid-stall or mid-flush SHALL take precedence; the following cycle with rst=0 SHALL behave per REQ-013.

Configuration
REQ-026 Macro EX_OPERAND_FORWARD_EN SHALL select the forwarding mode.
REQ-027 With EX_OPERAND_FORWARD_EN defined, REQ-017/018 SHALL apply.
REQ-028 With EX_OPERAND_FORWARD_EN defined, hazardStall SHALL be idValid & exValid & exIsLoad & exRegWrite & ((idUsesA & exDest==idSrcA) | (idUsesB & ~idUseImm & exDest==idSrcB)).
REQ-029 Without EX_OPERAND_FORWARD_EN, operands SHALL come only from idRegA/idRegB/idImm.
REQ-030 Without EX_OPERAND_FORWARD_EN, hazardStall SHALL assert when idValid and a used source matches exDest with exValid&exRegWrite, exmDest with exmRegWrite, or mwbDest with mwbRegWrite.

Verification
REQ-031 rst=1 one cycle with arbitrary inputs -> all outputs 0 next cycle.
REQ-032 FORWARD_EN: idSrcA=3, idRegA=0x1111, exmRegWrite=1, exmDest=3, exmData=0xBEEF, mwbDest=3, mwbData=0xCAFE -> exA=0xBEEF.
REQ-033 idUseImm=1, idImm=0xFFF0, mwb match on idSrcB -> exB=0xFFF0.
REQ-034 Capture 0x0005/0x0007, then stall=1 for 3 cycles with new inputs -> exA=0x0005, exB=0x0007 held; flush+stall together -> exValid=0.
REQ-035 FORWARD_EN: exValid=1, exIsLoad=1, exRegWrite=1, exDest=2, idValid=1, idUsesB=1, idSrcB=2 -> hazardStall=1; same case with idUseImm=1 -> hazardStall=0.
REQ-036 No FORWARD_EN: mwbRegWrite=1, mwbDest=4, idUsesA=1, idSrcA=4 -> hazardStall=1 and exA=idRegA.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID->EX pipeline register: operand capture with writeback forwarding and hazard detection.
// Optional feature macro EX_OPERAND_FORWARD_EN: forwarding + load-use stall (default: interlock only).
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        idValid,
  input  logic        idUsesA,
  input  logic        idUsesB,
  input  logic        idUseImm,
  input  logic        idIsLoad,
  input  logic        idRegWrite,
  input  logic [15:0] idRegA,
  input  logic [15:0] idRegB,
  input  logic [15:0] idImm,
  input  logic [2:0]  idSrcA,
  input  logic [2:0]  idSrcB,
  input  logic [2:0]  idDest,
  input  logic [2:0]  idAluOp,
  input  logic        idInvA,
  input  logic        idInvB,
  input  logic        idCin,
  input  logic        idSign,
  input  logic        exmRegWrite,
  input  logic        mwbRegWrite,
  input  logic [2:0]  exmDest,
  input  logic [2:0]  mwbDest,
  input  logic [15:0] exmData,
  input  logic [15:0] mwbData,
  output logic        exValid,
  output logic        exRegWrite,
  output logic        exIsLoad,
  output logic [15:0] exA,
  output logic [15:0] exB,
  output logic [2:0]  exOp,
  output logic        exInvA,
  output logic        exInvB,
  output logic        exCin,
  output logic        exSign,
  output logic [2:0]  exDest,
  output logic        hazardStall
);

  logic        ex_valid_q, ex_valid_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic [15:0] ex_a_q, ex_a_d;
  logic [15:0] ex_b_q, ex_b_d;
  logic [2:0]  ex_op_q, ex_op_d;
  logic        ex_inv_a_q, ex_inv_a_d;
  logic        ex_inv_b_q, ex_inv_b_d;
  logic        ex_cin_q, ex_cin_d;
  logic        ex_sign_q, ex_sign_d;
  logic [2:0]  ex_dest_q, ex_dest_d;

  logic [15:0] op_a_s;
  logic [15:0] op_b_s;
  logic        src_a_used_s;
  logic        src_b_used_s;
  logic        hazard_s;

  // EX/MEM result beats MEM/WB result; register 0 is an ordinary forwardable register.
  function automatic logic [15:0] fwd_select(
    input logic [2:0]  src,
    input logic [15:0] rf_data,
    input logic        exm_we,
    input logic [2:0]  exm_dst,
    input logic [15:0] exm_data,
    input logic        mwb_we,
    input logic [2:0]  mwb_dst,
    input logic [15:0] mwb_data
  );
    logic [15:0] sel;
    if (exm_we && (exm_dst == src)) begin
      sel = exm_data;
    end else if (mwb_we && (mwb_dst == src)) begin
      sel = mwb_data;
    end else begin
      sel = rf_data;
    end
    return sel;
  endfunction

  function automatic logic reg_match(input logic we, input logic [2:0] dst, input logic [2:0] src);
    return we & (dst == src);
  endfunction

  assign src_a_used_s = idUsesA;
  assign src_b_used_s = idUsesB & ~idUseImm;

`ifdef EX_OPERAND_FORWARD_EN
  // Operand selection with forwarding.
  always_comb begin
    op_a_s = fwd_select(idSrcA, idRegA, exmRegWrite, exmDest, exmData,
                        mwbRegWrite, mwbDest, mwbData);
    if (idUseImm) begin
      op_b_s = idImm;
    end else begin
      op_b_s = fwd_select(idSrcB, idRegB, exmRegWrite, exmDest, exmData,
                          mwbRegWrite, mwbDest, mwbData);
    end
  end

  // Only a load in EX cannot be forwarded in time.
  always_comb begin
    hazard_s = idValid & ex_valid_q & ex_is_load_q & ex_reg_write_q &
               ((src_a_used_s & (ex_dest_q == idSrcA)) |
                (src_b_used_s & (ex_dest_q == idSrcB)));
  end
`else
  // Operand selection straight from the register file / immediate.
  always_comb begin
    op_a_s = idRegA;
    if (idUseImm) begin
      op_b_s = idImm;
    end else begin
      op_b_s = idRegB;
    end
  end

  // Without forwarding, any in-flight writer of a used source blocks issue.
  always_comb begin
    hazard_s = idValid &
      ((src_a_used_s & (reg_match(ex_valid_q & ex_reg_write_q, ex_dest_q, idSrcA) |
                        reg_match(exmRegWrite, exmDest, idSrcA) |
                        reg_match(mwbRegWrite, mwbDest, idSrcA))) |
       (src_b_used_s & (reg_match(ex_valid_q & ex_reg_write_q, ex_dest_q, idSrcB) |
                        reg_match(exmRegWrite, exmDest, idSrcB) |
                        reg_match(mwbRegWrite, mwbDest, idSrcB))));
  end
`endif

  // Next state: flush squashes qualifiers only, stall holds everything, else capture.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_is_load_d   = ex_is_load_q;
    ex_a_d         = ex_a_q;
    ex_b_d         = ex_b_q;
    ex_op_d        = ex_op_q;
    ex_inv_a_d     = ex_inv_a_q;
    ex_inv_b_d     = ex_inv_b_q;
    ex_cin_d       = ex_cin_q;
    ex_sign_d      = ex_sign_q;
    ex_dest_d      = ex_dest_q;
    if (flush) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_is_load_d   = 1'b0;
    end else if (stall) begin
      ex_a_d = ex_a_q;
      ex_b_d = ex_b_q;
    end else begin
      ex_valid_d     = idValid;
      ex_reg_write_d = idRegWrite & idValid;
      ex_is_load_d   = idIsLoad;
      ex_a_d         = op_a_s;
      ex_b_d         = op_b_s;
      ex_op_d        = idAluOp;
      ex_inv_a_d     = idInvA;
      ex_inv_b_d     = idInvB;
      ex_cin_d       = idCin;
      ex_sign_d      = idSign;
      ex_dest_d      = idDest;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_a_q         <= 16'h0000;
      ex_b_q         <= 16'h0000;
      ex_op_q        <= 3'd0;
      ex_inv_a_q     <= 1'b0;
      ex_inv_b_q     <= 1'b0;
      ex_cin_q       <= 1'b0;
      ex_sign_q      <= 1'b0;
      ex_dest_q      <= 3'd0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_a_q         <= ex_a_d;
      ex_b_q         <= ex_b_d;
      ex_op_q        <= ex_op_d;
      ex_inv_a_q     <= ex_inv_a_d;
      ex_inv_b_q     <= ex_inv_b_d;
      ex_cin_q       <= ex_cin_d;
      ex_sign_q      <= ex_sign_d;
      ex_dest_q      <= ex_dest_d;
    end
  end

  assign exValid     = ex_valid_q;
  assign exRegWrite  = ex_reg_write_q;
  assign exIsLoad    = ex_is_load_q;
  assign exA         = ex_a_q;
  assign exB         = ex_b_q;
  assign exOp        = ex_op_q;
  assign exInvA      = ex_inv_a_q;
  assign exInvB      = ex_inv_b_q;
  assign exCin       = ex_cin_q;
  assign exSign      = ex_sign_q;
  assign exDest      = ex_dest_q;
  assign hazardStall = hazard_s;

endmodule
